// File: rtl/gray_updown_counter_pkg.sv
// Shared Gray-code helpers and mode constants for the Gray up/down counter family.
// The helpers work on 16-bit values; narrower counts are zero-extended, which leaves both codes unchanged.
package gray_pkg;

    localparam int GRAY_MAX_WIDTH = 16;
    localparam int GRAY_WRAP      = 0;
    localparam int GRAY_SAT       = 1;

    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] gray);
        logic [GRAY_MAX_WIDTH-1:0] bin;
        bin[GRAY_MAX_WIDTH-1] = gray[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_updown_counter_if.sv
// Control and count bus of the Gray up/down counter.
// The master drives the controls; the counter (slave) returns the count views and carry.
interface gray_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             CLR;
    logic             LOAD;
    logic [WIDTH-1:0] LOAD_BIN;
    logic             EN;
    logic             UP;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] QBIN;
    logic             CO;

    modport master (
        output CLR, LOAD, LOAD_BIN, EN, UP,
        input  Q, QBIN, CO
    );

    modport slave (
        input  CLR, LOAD, LOAD_BIN, EN, UP,
        output Q, QBIN, CO
    );

endinterface

// File: rtl/gray_updown_counter_gray2bin.sv
// Purely combinational Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits at and above its position.
module gray2bin_conv #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    logic [WIDTH-1:0] binAcc;

    always_comb begin
        binAcc            = '0;
        binAcc[WIDTH-1]   = gray_i[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            binAcc[i] = binAcc[i+1] ^ gray_i[i];
        end
        bin_o = binAcc;
    end

endmodule

// File: rtl/gray_updown_counter.sv
// Gray-code up/down counter with clear, binary load, enable and optional saturation.
// Only the Gray code is stored; the binary view is decoded from it, so Q stays one-bit-per-step safe.
module gray_updown_counter
    import gray_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int SATURATE = GRAY_WRAP
) (
    input  logic                  CLK,
    input  logic                  RESETL,
    gray_updown_counter_if.slave  bus
);

    if (WIDTH < 2 || WIDTH > GRAY_MAX_WIDTH) begin : gWidthCheck
        $error("gray_updown_counter: WIDTH must be within 2..16");
    end
    if (SATURATE != GRAY_WRAP && SATURATE != GRAY_SAT) begin : gModeCheck
        $error("gray_updown_counter: SATURATE must be 0 or 1");
    end

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] binCount;
    logic [WIDTH-1:0] binNext;
    logic             atTerminal;
    logic             holdAtEnd;

    gray2bin_conv #(
        .WIDTH (WIDTH)
    ) u_conv (
        .gray_i (count_q),
        .bin_o  (binCount)
    );

    always_comb begin
        atTerminal = bus.UP ? (binCount == {WIDTH{1'b1}}) : (binCount == '0);
        holdAtEnd  = (SATURATE == GRAY_SAT) && atTerminal;
        binNext    = bus.UP ? (binCount + WIDTH'(1)) : (binCount - WIDTH'(1));
    end

    // Priority: clear, then load, then an enabled step (suppressed at the end value when saturating).
    always_comb begin
        count_d = count_q;
        if (bus.CLR) begin
            count_d = '0;
        end else if (bus.LOAD) begin
            count_d = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(bus.LOAD_BIN)));
        end else if (bus.EN && !holdAtEnd) begin
            count_d = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(binNext)));
        end
    end

    always_ff @(posedge CLK or negedge RESETL) begin
        if (!RESETL) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.Q    = count_q;
    assign bus.QBIN = binCount;
    assign bus.CO   = bus.EN & ~bus.CLR & ~bus.LOAD & atTerminal;

endmodule
